// File: rtl/iter_div_if.sv
// iter_div_if: request/response bundle for the iterative divider.
//   master (requester): drives start, is_signed, dividend, divisor, flush;
//                       observes busy, done, div_result.
//   slave  (divider)  : the reverse.
// div_result packs {remainder, quotient}, each WIDTH bits.
interface iter_div_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               flush;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] div_result;

  modport master (
    output start, is_signed, dividend, divisor, flush,
    input  busy, done, div_result
  );

  modport slave (
    input  start, is_signed, dividend, divisor, flush,
    output busy, done, div_result
  );
endinterface

// File: rtl/iter_div.sv
// iter_div: multi-cycle radix-2 restoring divider (signed/unsigned, RISC-V
// corner cases). Start in cycle 0 -> busy in cycles 1..WIDTH+1, one-cycle done
// pulse with the new {remainder, quotient} in cycle WIDTH+2. Divide-by-zero and
// signed overflow finish in the cycle after start without raising busy.
// Ports:
//   clk   - rising-edge clock
//   rstn  - asynchronous active-low reset
//   io    - iter_div_if.slave (start/is_signed/dividend/divisor/flush in,
//           busy/done/div_result out)
module iter_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic      clk,
  input  logic      rstn,
  iter_div_if.slave io
);

  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL1 = '1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;   // settled remainder, always < |divisor|
  logic [WIDTH-1:0]   quo_q, quo_d;   // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   dvs_q, dvs_d;   // |divisor|
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  // Operand decode in IDLE
  logic             a_neg, b_neg, div0, ovf, accept;
  logic [WIDTH-1:0] a_abs, b_abs;

  // One restoring step: the shifted partial remainder is WIDTH+1 bits so the
  // trial subtract cannot overflow; its MSB is the borrow.
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] fix_quo, fix_rem;

  always_comb begin
    a_neg   = io.is_signed & io.dividend[WIDTH-1];
    b_neg   = io.is_signed & io.divisor[WIDTH-1];
    // |MIN| only reaches here when not overflowing; the wrapped value is the
    // correct unsigned magnitude.
    a_abs   = a_neg ? -io.dividend : io.dividend;
    b_abs   = b_neg ? -io.divisor  : io.divisor;
    div0    = (io.divisor == '0);
    ovf     = io.is_signed && (io.dividend == MIN) && (io.divisor == ALL1);
    accept  = io.start && !io.flush;
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    fix_quo = qneg_q ? -quo_q : quo_q;
    fix_rem = rneg_q ? -rem_q : rem_q;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && !div0 && !ovf) state_d = RUN;
      RUN: begin
        if (io.flush)                  state_d = IDLE;
        else if (cnt_q == CNT_W'(1))   state_d = FIX;
      end
      FIX:     state_d = IDLE;   // flush or complete, both leave FIX
      default: state_d = IDLE;
    endcase
  end

  // Datapath / outputs
  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    done_d = 1'b0;
    res_d  = res_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (div0) begin
            res_d  = {io.dividend, ALL1};
            done_d = 1'b1;
          end else if (ovf) begin
            res_d  = {{WIDTH{1'b0}}, MIN};
            done_d = 1'b1;
          end else begin
            cnt_d  = CNT_W'(WIDTH);
            rem_d  = '0;
            quo_d  = a_abs;
            dvs_d  = b_abs;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
          end
        end
      end
      RUN: begin
        if (!io.flush) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      FIX: begin
        if (!io.flush) begin
          res_d  = {fix_rem, fix_quo};
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    io.busy       = (state_q != IDLE);
    io.done       = done_q;
    io.div_result = res_q;
  end

endmodule

// File: doc/iter_div.md
Name: iter_div

Overview:
- Parametrised multi-cycle radix-2 integer divider that produces the div_result bus consumed by the ALU for divw/divwu/modw/modwu.
- Handles signed and unsigned operands with RISC-V corner-case semantics.
- Start/busy/done handshake, so the pipeline stalls while the divider runs.
- Width is generalised; a flush input cancels an operation in flight, for branch or exception squash.

Parameters:
- WIDTH, 32: operand width in bits (≥4, even).
- CNT_W, $clog2(WIDTH+1): width of the iteration counter.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = signed divide/rem, 0 = unsigned
- dividend  in  WIDTH  operand A, sampled with start
- divisor  in  WIDTH  operand B, sampled with start
- flush  in  1  synchronous cancel
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- div_result  out  2*WIDTH  {remainder, quotient}; held until next completion

Behaviour:
- Reset (rstn low, asynchronous):
  - FSM to IDLE.
  - busy=0, done=0, div_result=0, internal counter/registers=0.
  - Reset mid-operation discards the operation; no done is produced.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 and flush=0 captures operands and is_signed.
  - Divisor==0 → special case.
  - Signed, dividend==MIN (1 followed by zeros), divisor==all-ones → special case.
  - Otherwise go to RUN with counter=WIDTH, using absolute values when signed, and record sign flags.
- Special cases resolve without RUN; done=1 in the next cycle and busy stays 0:
  - Divide by zero: quotient = all ones, remainder = dividend, for both signed and unsigned.
  - Signed overflow: quotient = MIN, remainder = 0.
- RUN:
  - One restoring step per cycle: shift {rem, quo} left 1, trial-subtract |divisor|, set the quotient LSB if non-negative.
  - Counter decrements each step; when it reaches 1, go to FIX next.
- FIX:
  - Quotient negated if signed and operand signs differ.
  - Remainder takes the sign of the dividend: negated if signed and dividend negative.
  - Registers div_result, pulses done, returns to IDLE.
- Latency, start in cycle 0:
  - busy=1 in cycles 1..WIDTH+1.
  - done=1 and new div_result visible in cycle WIDTH+2, with busy=0 in that cycle.
- done:
  - Registered, high exactly one cycle per completed operation.
  - start in the same cycle as done is accepted.
- start while busy is ignored; no queueing.
- flush:
  - In RUN or FIX: FSM returns to IDLE next cycle, busy drops, no done, div_result keeps its previous value.
  - flush with start in IDLE: start is not accepted.
  - flush has priority over completion in FIX.
- div_result changes only on done cycles (or reset).
- Arithmetic:
  - Partial remainder is WIDTH+1 bits, so the trial subtract never overflows.
  - Absolute value of MIN only arises in non-overflow cases and is handled as the unsigned WIDTH-bit value.
- Operand inputs may change freely after the start cycle; the block uses the captured copies.

Test Plan:
- WIDTH=32, unsigned 100/7 → done in cycle 34, div_result={32'd2, 32'd14}; busy high cycles 1..33.
- Signed -7/2 (0xFFFFFFF9/0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 → quotient 0xFFFFFFFD, remainder 0x1.
- Unsigned 0xFFFFFFFF/0x10 → quotient 0x0FFFFFFF, remainder 0xF. Same operands signed → quotient 0, remainder 0xFFFFFFFF.
- Corner cases:
  - 0x1234/0 (either mode) → done in cycle 1, quotient 0xFFFFFFFF, remainder 0x1234, busy never high.
  - Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Handshake:
  - flush asserted in cycle 10 of an operation → busy=0 in cycle 11, no done, div_result unchanged.
  - start re-asserted while busy is ignored.
  - Back-to-back start on the done cycle yields a second done 34 cycles later.
- rstn pulled low mid-RUN (cycle 5) → busy, done, div_result read 0 immediately (asynchronously). After release, a fresh 100/7 completes normally.
